// File: rtl/packetizer_pkg.sv
// Shared definitions for the UART packetizer: FSM state encoding and default sync byte.
package packetizer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StLen,
      StData,
      StCsum,
      StGap
   } state_e;

   localparam logic [7:0] DefaultSyncByte = 8'hA5;

endpackage

// File: rtl/packetizer_fifo.sv
// Single-clock show-ahead byte FIFO. The head entry is visible combinationally.
// Writes are ignored when full and reads are ignored when empty.
module packetizer_fifo #(
   parameter int unsigned Depth = 128,
   parameter int unsigned Width = 8,
   localparam int unsigned AddrW = $clog2(Depth),
   localparam int unsigned CntW  = $clog2(Depth) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic             rd_en_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] head_o,
   output logic [CntW-1:0]  count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_wr, do_rd;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign do_wr   = wr_en_i && !full_o;
   assign do_rd   = rd_en_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer and occupancy next-state; pointers wrap naturally since Depth is a power of 2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AddrW'(1);
      if (do_wr && !do_rd) begin
         count_d = count_q + CntW'(1);
      end else if (!do_wr && do_rd) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_packetizer.sv
// Frames buffered compressor bytes into packets (sync, length, payload, xor checksum)
// and hands them to the UART one byte per handshake.
module uart_packetizer
   import packetizer_pkg::*;
#(
   parameter int unsigned PayloadLen    = 64,
   parameter int unsigned FifoDepth     = 128,
   parameter logic [7:0]  SyncByte      = DefaultSyncByte,
   parameter int unsigned TimeoutCycles = 50000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   input  logic       i_flush,
   input  logic       i_busy,
   output logic [7:0] o_frame,
   output logic       o_send,
   output logic       o_overflow
);

   localparam int unsigned CntW   = $clog2(FifoDepth) + 1;
   localparam int unsigned TimerW = $clog2(TimeoutCycles);
   localparam logic [CntW-1:0]   PayloadCnt = CntW'(PayloadLen);
   localparam logic [TimerW-1:0] TimerLast  = TimerW'(TimeoutCycles - 1);

   state_e            state_q, state_d;
   state_e            ret_q, ret_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        rem_q, rem_d;
   logic [7:0]        csum_q, csum_d;
   logic [7:0]        frame_q;
   logic              ovf_q, ovf_d;
   logic              flush_q, flush_d;
   logic [TimerW-1:0] timer_q, timer_d;

   logic [7:0]        head;
   logic [CntW-1:0]   count;
   logic              full, empty;
   logic              wr_acc, rd_en;
   logic              in_idle, trig;
   logic [7:0]        pkt_len;
   logic              send;
   logic [7:0]        byte_sel;

   // A full FIFO drops the byte even if a read frees a slot in the same cycle.
   assign wr_acc = i_valid && !full;

   packetizer_fifo #(
      .Depth (FifoDepth),
      .Width (8)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .wr_en_i (wr_acc),
      .rd_en_i (rd_en),
      .data_i  (i_data),
      .head_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   // Packet trigger, idle timer, flush latch and overflow flag.
   always_comb begin
      in_idle = (state_q == StIdle);
      trig    = in_idle && ((count >= PayloadCnt) ||
                            (!empty && (flush_q || (timer_q == TimerLast))));
      pkt_len = (count >= PayloadCnt) ? 8'(PayloadLen) : 8'(count);

      if (wr_acc) begin
         timer_d = '0;
      end else if (in_idle && !empty && !trig) begin
         timer_d = timer_q + TimerW'(1);
      end else begin
         timer_d = '0;
      end

      if (trig) begin
         flush_d = 1'b0;
      end else if (i_flush) begin
         flush_d = 1'b1;
      end else if (in_idle && empty) begin
         flush_d = 1'b0;
      end else begin
         flush_d = flush_q;
      end

      ovf_d = ovf_q | (i_valid & full);
   end

   // Packet FSM: every emitting state waits for the UART, sends one byte, then takes one GAP cycle.
   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      len_d    = len_q;
      rem_d    = rem_q;
      csum_d   = csum_q;
      send     = 1'b0;
      byte_sel = frame_q;
      rd_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (trig) begin
               state_d = StSync;
               len_d   = pkt_len;
               rem_d   = pkt_len;
               csum_d  = pkt_len;
            end
         end
         StSync: begin
            if (!i_busy) begin
               send     = 1'b1;
               byte_sel = SyncByte;
               ret_d    = StLen;
               state_d  = StGap;
            end
         end
         StLen: begin
            if (!i_busy) begin
               send     = 1'b1;
               byte_sel = len_q;
               ret_d    = StData;
               state_d  = StGap;
            end
         end
         StData: begin
            if (!i_busy) begin
               send     = 1'b1;
               byte_sel = head;
               rd_en    = 1'b1;
               csum_d   = csum_q ^ head;
               rem_d    = rem_q - 8'd1;
               ret_d    = (rem_q == 8'd1) ? StCsum : StData;
               state_d  = StGap;
            end
         end
         StCsum: begin
            if (!i_busy) begin
               send     = 1'b1;
               byte_sel = csum_q;
               ret_d    = StIdle;
               state_d  = StGap;
            end
         end
         StGap: begin
            state_d = ret_q;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Frame is driven on the strobe cycle and held from the register afterwards.
   assign o_send     = send;
   assign o_frame    = send ? byte_sel : frame_q;
   assign o_overflow = ovf_q;

   // State, packet bookkeeping and output-holding registers.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= StIdle;
         ret_q   <= StIdle;
         len_q   <= '0;
         rem_q   <= '0;
         csum_q  <= '0;
         frame_q <= '0;
         ovf_q   <= 1'b0;
         flush_q <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         csum_q  <= csum_d;
         frame_q <= o_frame;
         ovf_q   <= ovf_d;
         flush_q <= flush_d;
         timer_q <= timer_d;
      end
   end

endmodule

// File: tb/tb_uart_packetizer.sv
// Self-checking bench for uart_packetizer: packet-level reference model plus directed scenarios.
module tb_uart_packetizer;

   localparam int unsigned P = 64;
   localparam int unsigned D = 128;
   localparam int unsigned T = 100;
   localparam logic [7:0]  Sync = 8'hA5;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] i_data = 8'h00;
   logic       i_valid = 1'b0;
   logic       i_flush = 1'b0;
   logic       i_busy = 1'b0;
   logic [7:0] o_frame;
   logic       o_send;
   logic       o_overflow;

   always #5 CLK = ~CLK;

   uart_packetizer #(
      .PayloadLen    (P),
      .FifoDepth     (D),
      .SyncByte      (Sync),
      .TimeoutCycles (T)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .i_flush    (i_flush),
      .i_busy     (i_busy),
      .o_frame    (o_frame),
      .o_send     (o_send),
      .o_overflow (o_overflow)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference model: FIFO as a queue, current packet as a list of bytes still to emit.
   typedef struct {
      bit         d;
      logic [7:0] b;
   } item_t;
   typedef struct {
      int         c;
      logic [7:0] b;
   } cap_t;

   logic [7:0] mq[$];
   item_t      pkt[$];
   cap_t       cap[$];
   bit         m_in_pkt = 0, m_gap = 0, m_ovf = 0, m_fp = 0, model_on = 0;
   int         m_timer = 0;
   logic [7:0] m_frame = 8'h00;
   bit         send_seen = 0;
   int         last_wr_cyc = 0;

   always @(negedge CLK) begin : compare
      bit         es;
      logic [7:0] ef;
      int         sz, len;
      bit         idle, trig, wr;
      logic [7:0] cs;
      item_t      it;
      cap_t       cp;
      cyc++;
      send_seen = o_send;
      es = 0;
      if (model_on) begin
         es = m_in_pkt && !m_gap && !i_busy && (pkt.size() > 0);
         ef = es ? pkt[0].b : m_frame;
         chk("o_send", 32'(o_send), 32'(es));
         chk("o_frame", 32'(o_frame), 32'(ef));
         chk("o_overflow", 32'(o_overflow), 32'(m_ovf));
         chk("send_while_busy", 32'(o_send && i_busy), 32'd0);
         if (o_send === 1'b1) begin
            cp.c = cyc;
            cp.b = o_frame;
            cap.push_back(cp);
         end
      end
      if (i_valid && RST) last_wr_cyc = cyc;
      if (!RST) begin
         mq.delete();
         pkt.delete();
         m_in_pkt = 0;
         m_gap = 0;
         m_ovf = 0;
         m_fp = 0;
         m_timer = 0;
         m_frame = 8'h00;
         model_on = 1;
      end else begin
         sz = mq.size();
         idle = !m_in_pkt;
         trig = idle && ((sz >= int'(P)) || (sz > 0 && (m_fp || m_timer == int'(T) - 1)));
         wr = i_valid && (sz < int'(D));
         if (i_valid && !wr) m_ovf = 1;
         if (wr) m_timer = 0;
         else if (idle && sz > 0 && !trig) m_timer = m_timer + 1;
         else m_timer = 0;
         if (trig) m_fp = 0;
         else if (i_flush) m_fp = 1;
         else if (idle && sz == 0) m_fp = 0;
         if (es) begin
            m_frame = pkt[0].b;
            if (pkt[0].d) void'(mq.pop_front());
            void'(pkt.pop_front());
            m_gap = 1;
         end else if (m_in_pkt && m_gap) begin
            m_gap = 0;
            if (pkt.size() == 0) m_in_pkt = 0;
         end
         if (trig) begin
            len = (sz >= int'(P)) ? int'(P) : sz;
            cs = 8'(len);
            it.d = 0; it.b = Sync;     pkt.push_back(it);
            it.d = 0; it.b = 8'(len);  pkt.push_back(it);
            for (int i = 0; i < len; i++) begin
               it.d = 1; it.b = mq[i];
               pkt.push_back(it);
               cs = cs ^ mq[i];
            end
            it.d = 0; it.b = cs;       pkt.push_back(it);
            m_in_pkt = 1;
            m_gap = 0;
         end
         if (wr) mq.push_back(i_data);
      end
   end

   // UART stand-in: busy for busy_left cycles starting two cycles after each send.
   int busy_mode = 0, busy_fix = 10, busy_left = 0;
   bit busy_hold = 0, hist1 = 0, hist2 = 0;

   task automatic step(input bit v, input logic [7:0] d, input bit f);
      i_valid = v;
      i_data  = d;
      i_flush = f;
      @(posedge CLK);
      #1;
      i_valid = 1'b0;
      i_flush = 1'b0;
      hist2 = hist1;
      hist1 = send_seen;
      if (hist2 && busy_mode == 1) busy_left = busy_fix;
      else if (hist2 && busy_mode == 2) busy_left = $urandom_range(0, 6);
      i_busy = busy_hold || (busy_left > 0);
      if (busy_left > 0) busy_left--;
   endtask

   task automatic idle_n(input int n);
      repeat (n) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      busy_left = 0;
      RST = 1'b0;
      idle_n(2);
      RST = 1'b1;
      cap.delete();
   endtask

   task automatic wait_caps(input int n, input int budget, input string name);
      int k = 0;
      while (cap.size() < n && k < budget) begin
         step(1'b0, 8'h00, 1'b0);
         k++;
      end
      chk({name, "_count"}, 32'(cap.size() >= n), 32'd1);
   endtask

   function automatic logic [7:0] cb(input int k);
      return (k < cap.size()) ? cap[k].b : 8'hxx;
   endfunction

   function automatic int cc(input int k);
      return (k < cap.size()) ? cap[k].c : -1;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int bad;
      logic [7:0] exp6[6];
      logic [7:0] exp8[8];

      RST = 1'b0;
      idle_n(3);
      RST = 1'b1;
      chk("reset_o_send", 32'(o_send), 32'd0);
      chk("reset_o_frame", 32'(o_frame), 32'd0);
      chk("reset_o_overflow", 32'(o_overflow), 32'd0);
      cap.delete();

      // Full payload, one byte every 4 cycles.
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 8'(i), 1'b0);
         idle_n(3);
      end
      wait_caps(67, 400, "full");
      chk("full_sync", 32'(cb(0)), 32'hA5);
      chk("full_len", 32'(cb(1)), 32'h40);
      bad = 0;
      for (int k = 0; k < 64; k++) if (cb(k + 2) !== 8'(k)) bad++;
      chk("full_data", 32'(bad), 32'd0);
      chk("full_csum", 32'(cb(66)), 32'h40);
      bad = 0;
      for (int k = 0; k < 66; k++) if (cc(k + 1) - cc(k) != 2) bad++;
      chk("full_spacing", 32'(bad), 32'd0);

      // Flush, then a flush with nothing buffered.
      do_reset();
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      wait_caps(6, 100, "flush");
      exp6 = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      bad = 0;
      for (int k = 0; k < 6; k++) if (cb(k) !== exp6[k]) bad++;
      chk("flush_bytes", 32'(bad), 32'd0);
      idle_n(4);
      cap.delete();
      step(1'b0, 8'h00, 1'b1);
      idle_n(30);
      chk("empty_flush_no_send", 32'(cap.size()), 32'd0);
      step(1'b1, 8'h55, 1'b0);
      wait_caps(4, 300, "after_empty_flush");
      chk("flush_pend_cleared", 32'(cc(0) - last_wr_cyc), 32'd101);

      // Idle timeout.
      do_reset();
      step(1'b1, 8'h7E, 1'b0);
      wait_caps(4, 300, "timeout");
      chk("timeout_latency", 32'(cc(0) - last_wr_cyc), 32'd101);
      chk("timeout_sync", 32'(cb(0)), 32'hA5);
      chk("timeout_len", 32'(cb(1)), 32'h01);
      chk("timeout_data", 32'(cb(2)), 32'h7E);
      chk("timeout_csum", 32'(cb(3)), 32'h7F);

      // Overflow with the UART held busy.
      do_reset();
      busy_hold = 1;
      i_busy = 1'b1;
      for (int i = 0; i < 130; i++) begin
         step(1'b1, 8'(i), 1'b0);
         if (i == 127) chk("ovf_before_drop", 32'(o_overflow), 32'd0);
         if (i == 128) chk("ovf_after_drop", 32'(o_overflow), 32'd1);
      end
      chk("ovf_no_send_while_busy", 32'(cap.size()), 32'd0);
      busy_hold = 0;
      wait_caps(134, 600, "ovf_drain");
      chk("ovf_p1_sync", 32'(cb(0)), 32'hA5);
      chk("ovf_p1_len", 32'(cb(1)), 32'h40);
      chk("ovf_p1_csum", 32'(cb(66)), 32'h40);
      chk("ovf_p2_sync", 32'(cb(67)), 32'hA5);
      chk("ovf_p2_len", 32'(cb(68)), 32'h40);
      chk("ovf_p2_csum", 32'(cb(133)), 32'h40);
      bad = 0;
      for (int k = 0; k < 64; k++) begin
         if (cb(k + 2) !== 8'(k)) bad++;
         if (cb(k + 69) !== 8'(k + 64)) bad++;
      end
      chk("ovf_payloads", 32'(bad), 32'd0);
      chk("ovf_sticky", 32'(o_overflow), 32'd1);

      // Busy handshake: 10 busy cycles per byte.
      do_reset();
      busy_mode = 1;
      busy_fix = 10;
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      wait_caps(6, 200, "busy");
      bad = 0;
      for (int k = 0; k < 5; k++) if (cc(k + 1) - cc(k) != 12) bad++;
      chk("busy_spacing", 32'(bad), 32'd0);
      busy_mode = 0;
      idle_n(15);

      // Reset in the middle of a packet.
      do_reset();
      for (int i = 0; i < 64; i++) step(1'b1, 8'(128 + i), 1'b0);
      wait_caps(12, 200, "midpkt");
      RST = 1'b0;
      step(1'b0, 8'h00, 1'b0);
      RST = 1'b1;
      chk("midrst_send", 32'(o_send), 32'd0);
      chk("midrst_frame", 32'(o_frame), 32'd0);
      chk("midrst_overflow", 32'(o_overflow), 32'd0);
      cap.delete();
      for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
      wait_caps(8, 100, "fresh");
      exp8 = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h04};
      bad = 0;
      for (int k = 0; k < 8; k++) if (cb(k) !== exp8[k]) bad++;
      chk("fresh_packet", 32'(bad), 32'd0);

      // Randomized traffic checked cycle by cycle against the model.
      do_reset();
      busy_mode = 2;
      repeat (3000) step($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 199) == 0);
      busy_mode = 0;
      repeat (2000) step($urandom_range(0, 99) < 20, 8'($urandom), $urandom_range(0, 99) == 0);
      repeat (1500) step($urandom_range(0, 149) == 0, 8'($urandom), 1'b0);
      chk("random_sends_seen", 32'(cap.size() > 100), 32'd1);
      step(1'b0, 8'h00, 1'b1);
      idle_n(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_packetizer.md
# uart_packetizer

Framing stage between the pixel Compressor and the UART transmitter, clocked in the system `CLK` domain. Compressed bytes are buffered in an internal FIFO and re-emitted to the UART one byte per handshake as packets of the form sync byte, length, payload, checksum. A packet starts when a full payload is buffered, on an explicit flush, or after an idle timeout.

## Interface
- `PayloadLen`, 64: max payload bytes per packet; legal range 1..255.
- `FifoDepth`, 128: buffer depth in bytes; power of 2, ≥ `PayloadLen`.
- `SyncByte`, 8'hA5: first byte of every packet.
- `TimeoutCycles`, 50000: idle cycles after the last accepted write before a partial packet is forced out; ≥ 2.
- `CLK` in 1: system clock; the only clock.
- `RST` in 1: reset, synchronous, active-low.
- `i_data` in 8: compressed byte from the Compressor.
- `i_valid` in 1: one-cycle strobe; `i_data` is valid.
- `i_flush` in 1: one-cycle strobe; send buffered bytes now.
- `i_busy` in 1: UART transmitting; high from the cycle after its `i_send` until the byte is done.
- `o_frame` out 8: byte to the UART; held stable between strobes.
- `o_send` out 1: one-cycle strobe to the UART `i_send`.
- `o_overflow` out 1: sticky; a byte was dropped because the FIFO was full.

## Operation
- **Write side.** A byte is accepted when `i_valid`=1 and count<`FifoDepth`. It is dropped when count==`FifoDepth`, even if a read occurs in the same cycle. A drop sets `o_overflow` until reset.
- **FIFO.** Show-ahead: the head byte is visible combinationally. Read and write in the same cycle are legal (count unchanged). Pointers wrap modulo `FifoDepth`.
- **Flush.** `i_flush` sets `flush_pend`. It is cleared when a packet starts. A flush with an empty FIFO is cleared without sending.
- **Idle timer.** Counts while in IDLE with count>0. It resets to 0 on every accepted write, and freezes and clears outside IDLE.
- **Packet trigger** (evaluated in IDLE): count≥`PayloadLen`, OR count>0 AND (`flush_pend` OR timer==`TimeoutCycles`-1).
  - On trigger, latch L=min(count,`PayloadLen`) and set checksum register = L.
- **FSM states:** IDLE → SYNC → LEN → DATA (L bytes) → CSUM → IDLE.
  - Each emitting state waits for `i_busy`=0, drives `o_frame` and pulses `o_send`, then enters GAP for exactly one cycle (ignoring `i_busy`) before the next state.
  - In DATA, the FIFO head is read on the `o_send` cycle and XORed into the checksum. A down-counter tracks the remaining bytes.
  - CSUM emits the XOR of L and all payload bytes.
- **Concurrent writes.** Writes keep being accepted during a packet. Bytes arriving mid-packet go to the next packet.

## Timing
- **Reset values:** `o_frame`=0, `o_send`=0, `o_overflow`=0, FIFO empty, state IDLE, timer 0, `flush_pend` 0.
- **Trigger to sync:** trigger seen at cycle t → sync `o_send` at t+1 if `i_busy`=0.
- **Byte rate:** with `i_busy` tied low, successive `o_send` pulses are exactly 2 cycles apart, so a packet takes 2·(L+3) cycles.
- **Busy handling:** `o_send` is never asserted while `i_busy`=1.
- **Accepted-write latency:** an accepted write is visible to the trigger logic on the next cycle.
- **Reset mid-packet:** the packet is abandoned, with no trailing checksum and buffered bytes lost. The next packet starts with `SyncByte`.

## Structure
- **Shared package `packetizer_pkg`:** state encoding (IDLE, SYNC, LEN, DATA, CSUM, GAP) and the default `SyncByte` constant.
- **Sub-module `packetizer_fifo`:** synchronous show-ahead FIFO, single clock, parameterised depth and width 8. Ports: write enable, read enable, data in, head out, count, full, empty.
- **Top level:** FSM, idle timer, flush latch and checksum register.

## Test plan
- **Full-payload packet:** defaults, `i_busy`=0, write bytes 0x00..0x3F one every 4 cycles → A5, 40, 00..3F, 40. `o_send` pulses 2 cycles apart once triggered.
- **Flush:** write 11, 22, 33, then `i_flush` → A5, 03, 11, 22, 33, 03; `flush_pend` cleared. A second flush with the FIFO empty → no `o_send`.
- **Timeout:** `TimeoutCycles`=100, write 7E then idle → sync `o_send` 101 cycles after the write; bytes A5, 01, 7E, 7F.
- **Overflow:** hold `i_busy`=1, write 130 bytes → 128 stored, `o_overflow`=1 from the cycle after byte 129, no `o_send`. Release busy → two 64-byte packets with the correct contents.
- **Busy handshake:** UART model raises `i_busy` for 10 cycles after each `o_send` → no `o_send` while busy, pulse spacing 12 cycles.
- **Reset mid-packet:** pull `RST` low after 10 payload bytes → next cycle `o_send`=0, `o_frame`=0, `o_overflow`=0. Write 5 bytes plus flush → a fresh packet A5, 05, ….
